// File: rtl/tile_sequencer.sv
// Tile sequencer: walks a K x N grid of matrix-multiply tiles (k inner, n outer) and issues
// buffer offsets to the core. Define TILE_SEQ_PERF_EN to build the busy-cycle counter.
module tile_sequencer #(
    parameter int unsigned W_SIZE = 256,
    parameter int unsigned I_SIZE = 256,
    parameter int unsigned O_SIZE = 256,
    parameter int unsigned TILE_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_sync_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [TILE_W-1:0]         cfg_k_tiles_i,
    input  logic [TILE_W-1:0]         cfg_n_tiles_i,
    input  logic [$clog2(W_SIZE)-1:0] cfg_w_base_i,
    input  logic [$clog2(W_SIZE)-1:0] cfg_w_stride_i,
    input  logic [$clog2(I_SIZE)-1:0] cfg_i_base_i,
    input  logic [$clog2(I_SIZE)-1:0] cfg_i_stride_i,
    input  logic [$clog2(O_SIZE)-1:0] cfg_o_base_i,
    input  logic [$clog2(O_SIZE)-1:0] cfg_o_stride_i,
    input  logic                      abort_i,
    output logic                      mm_start_o,
    input  logic                      mm_done_i,
    output logic [$clog2(W_SIZE)-1:0] mm_w_offset_o,
    output logic [$clog2(I_SIZE)-1:0] mm_i_offset_o,
    output logic [$clog2(O_SIZE)-1:0] mm_psum_offset_o,
    output logic [$clog2(O_SIZE)-1:0] mm_o_offset_o,
    output logic                      mm_accum_en_o,
    output logic [TILE_W-1:0]         tile_k_o,
    output logic [TILE_W-1:0]         tile_n_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [31:0]               perf_cycles_o
);

    localparam int unsigned WW = $clog2(W_SIZE);
    localparam int unsigned IW = $clog2(I_SIZE);
    localparam int unsigned OW = $clog2(O_SIZE);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StNext} state_e;

    state_e            state_q;
    logic [TILE_W-1:0] k_q, n_q, k_last_q, n_last_q;
    logic [WW-1:0]     w_off_q, w_stride_q;
    logic [IW-1:0]     i_off_q, i_base_q, i_stride_q;
    logic [OW-1:0]     o_off_q, o_stride_q;
    logic              start_q, done_q;
    logic              last_tile;

    assign last_tile = (k_q == k_last_q) && (n_q == n_last_q);

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state_q    <= StIdle;
            k_q        <= '0;
            n_q        <= '0;
            k_last_q   <= '0;
            n_last_q   <= '0;
            w_off_q    <= '0;
            w_stride_q <= '0;
            i_off_q    <= '0;
            i_base_q   <= '0;
            i_stride_q <= '0;
            o_off_q    <= '0;
            o_stride_q <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        // A zero tile count is treated as a single tile.
                        k_last_q   <= (cfg_k_tiles_i == '0) ? '0 : cfg_k_tiles_i - TILE_W'(1);
                        n_last_q   <= (cfg_n_tiles_i == '0) ? '0 : cfg_n_tiles_i - TILE_W'(1);
                        w_stride_q <= cfg_w_stride_i;
                        i_base_q   <= cfg_i_base_i;
                        i_stride_q <= cfg_i_stride_i;
                        o_stride_q <= cfg_o_stride_i;
                        w_off_q    <= cfg_w_base_i;
                        i_off_q    <= cfg_i_base_i;
                        o_off_q    <= cfg_o_base_i;
                        k_q        <= '0;
                        n_q        <= '0;
                        start_q    <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= abort_i ? StIdle : StWait;
                end
                StWait: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                    end else if (mm_done_i) begin
                        done_q  <= last_tile;
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (abort_i || last_tile) begin
                        state_q <= StIdle;
                    end else begin
                        w_off_q <= w_off_q + w_stride_q;
                        if (k_q == k_last_q) begin
                            k_q     <= '0;
                            n_q     <= n_q + TILE_W'(1);
                            i_off_q <= i_base_q;
                            o_off_q <= o_off_q + o_stride_q;
                        end else begin
                            k_q     <= k_q + TILE_W'(1);
                            i_off_q <= i_off_q + i_stride_q;
                        end
                        start_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o      = (state_q == StIdle);
    assign busy_o           = (state_q != StIdle);
    assign mm_start_o       = start_q;
    assign done_o           = done_q;
    assign mm_w_offset_o    = w_off_q;
    assign mm_i_offset_o    = i_off_q;
    assign mm_o_offset_o    = o_off_q;
    assign mm_psum_offset_o = o_off_q;
    assign mm_accum_en_o    = (k_q != '0);
    assign tile_k_o         = k_q;
    assign tile_n_o         = n_q;

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            perf_q <= '0;
        end else if (state_q == StIdle) begin
            if (cmd_valid_i) begin
                perf_q <= '0;
            end
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer: directed and randomized jobs checked against a
// closed-form model of the tile walk (offsets computed directly from tile indices).
module tb_tile_sequencer;

    localparam int unsigned W_SIZE = 256;
    localparam int unsigned I_SIZE = 256;
    localparam int unsigned O_SIZE = 256;
    localparam int unsigned TILE_W = 8;

    logic        clk = 1'b0;
    logic        rst_sync = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cfg_k_tiles = '0, cfg_n_tiles = '0;
    logic [7:0]  cfg_w_base = '0, cfg_w_stride = '0;
    logic [7:0]  cfg_i_base = '0, cfg_i_stride = '0;
    logic [7:0]  cfg_o_base = '0, cfg_o_stride = '0;
    logic        abort = 1'b0;
    logic        mm_start;
    logic        mm_done = 1'b0;
    logic [7:0]  mm_w_offset, mm_i_offset, mm_psum_offset, mm_o_offset;
    logic        mm_accum_en;
    logic [7:0]  tile_k, tile_n;
    logic        busy, done;
    logic [31:0] perf_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    tile_sequencer #(
        .W_SIZE(W_SIZE),
        .I_SIZE(I_SIZE),
        .O_SIZE(O_SIZE),
        .TILE_W(TILE_W)
    ) dut (
        .clk_i           (clk),
        .rst_sync_i      (rst_sync),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cfg_k_tiles_i   (cfg_k_tiles),
        .cfg_n_tiles_i   (cfg_n_tiles),
        .cfg_w_base_i    (cfg_w_base),
        .cfg_w_stride_i  (cfg_w_stride),
        .cfg_i_base_i    (cfg_i_base),
        .cfg_i_stride_i  (cfg_i_stride),
        .cfg_o_base_i    (cfg_o_base),
        .cfg_o_stride_i  (cfg_o_stride),
        .abort_i         (abort),
        .mm_start_o      (mm_start),
        .mm_done_i       (mm_done),
        .mm_w_offset_o   (mm_w_offset),
        .mm_i_offset_o   (mm_i_offset),
        .mm_psum_offset_o(mm_psum_offset),
        .mm_o_offset_o   (mm_o_offset),
        .mm_accum_en_o   (mm_accum_en),
        .tile_k_o        (tile_k),
        .tile_n_o        (tile_n),
        .busy_o          (busy),
        .done_o          (done),
        .perf_cycles_o   (perf_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_start"}, mm_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_w"}, mm_w_offset, 0);
        chk({tag, "_i"}, mm_i_offset, 0);
        chk({tag, "_o"}, mm_o_offset, 0);
        chk({tag, "_psum"}, mm_psum_offset, 0);
        chk({tag, "_accum"}, mm_accum_en, 0);
        chk({tag, "_tk"}, tile_k, 0);
        chk({tag, "_tn"}, tile_n, 0);
        chk({tag, "_perf"}, perf_cycles, 0);
    endtask

    // Core emulator plus model: tile t sits at (k = t % K, n = t / K); every tile takes
    // ISSUE + d WAIT cycles + NEXT of busy time.
    task automatic run_job(input int k, input int n, input int wb, input int ws, input int ib,
                           input int is, input int ob, input int os, input bit hold_valid,
                           input bit spurious, input int fixed_d, input int abort_tile,
                           input int reset_tile);
        int ke, ne, tiles, d, perf, kk, nn, ew, ei, eo;
        ke    = (k == 0) ? 1 : k;
        ne    = (n == 0) ? 1 : n;
        tiles = ke * ne;
        perf  = 0;
        chk("ready_before_cmd", cmd_ready, 1);
        cfg_k_tiles  = 8'(k);
        cfg_n_tiles  = 8'(n);
        cfg_w_base   = 8'(wb);
        cfg_w_stride = 8'(ws);
        cfg_i_base   = 8'(ib);
        cfg_i_stride = 8'(is);
        cfg_o_base   = 8'(ob);
        cfg_o_stride = 8'(os);
        cmd_valid    = 1'b1;
        tick;
        if (!hold_valid) cmd_valid = 1'b0;
        for (int t = 0; t < tiles; t++) begin
            kk = t % ke;
            nn = t / ke;
            ew = (wb + t * ws) % W_SIZE;
            ei = (ib + kk * is) % I_SIZE;
            eo = (ob + nn * os) % O_SIZE;
            chk("start", mm_start, 1);
            chk("w_off", mm_w_offset, ew);
            chk("i_off", mm_i_offset, ei);
            chk("o_off", mm_o_offset, eo);
            chk("psum_off", mm_psum_offset, eo);
            chk("accum_en", mm_accum_en, (kk != 0) ? 1 : 0);
            chk("tile_k", tile_k, kk);
            chk("tile_n", tile_n, nn);
            chk("busy", busy, 1);
            chk("ready_busy", cmd_ready, 0);
            d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 4));
            if (spurious) mm_done = 1'b1;
            tick;
            mm_done = 1'b0;
            chk("start_one_cycle", mm_start, 0);
            for (int j = 1; j < d; j++) tick;
            if (reset_tile == t) begin
                cmd_valid = 1'b0;
                rst_sync  = 1'b1;
                tick;
                rst_sync  = 1'b0;
                chk_reset_state("mid_reset");
                return;
            end
            chk("w_stable", mm_w_offset, ew);
            chk("i_stable", mm_i_offset, ei);
            chk("o_stable", mm_o_offset, eo);
            mm_done = 1'b1;
            if (abort_tile == t) abort = 1'b1;
            tick;
            mm_done = 1'b0;
            abort   = 1'b0;
            perf += d + 2;
            if (abort_tile == t) begin
                chk("abort_ready", cmd_ready, 1);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                tick;
                chk("abort_done_later", done, 0);
                chk("abort_start_later", mm_start, 0);
                return;
            end
            if (t == tiles - 1) begin
                chk("done_pulse", done, 1);
                chk("no_start_last", mm_start, 0);
                if (hold_valid) cmd_valid = 1'b0;
                tick;
                chk("done_one_cycle", done, 0);
                chk("ready_after", cmd_ready, 1);
                chk("busy_after", busy, 0);
`ifdef TILE_SEQ_PERF_EN
                chk("perf", perf_cycles, perf);
`else
                chk("perf", perf_cycles, 0);
`endif
                tick;
                chk("perf_hold_idle", perf_cycles, perf_cycles);
            end else begin
                chk("done_not_last", done, 0);
                chk("start_gap", mm_start, 0);
                tick;
            end
        end
    endtask

    initial begin
        // Reset dominates a pending command.
        cmd_valid = 1'b1;
        tick;
        tick;
        cmd_valid = 1'b0;
        chk_reset_state("reset");
        rst_sync = 1'b0;
        tick;
        chk_reset_state("post_reset");

        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("idle_abort_ready", cmd_ready, 1);
        chk("idle_abort_busy", busy, 0);

        // 2x2 reference job, done three cycles after each start.
        run_job(2, 2, 0, 8, 0, 4, 16, 8, 1'b0, 1'b0, 3, -1, -1);
        // Zero tile counts behave as a single tile.
        run_job(0, 0, 5, 7, 9, 3, 11, 2, 1'b0, 1'b0, 0, -1, -1);
        // Weight offset wraps past the buffer depth: 250, then 2.
        run_job(2, 1, 250, 8, 0, 1, 0, 1, 1'b0, 1'b0, 0, -1, -1);
        // Command held valid for the whole job, plus done pulses during ISSUE.
        run_job(3, 2, 1, 2, 3, 4, 5, 6, 1'b1, 1'b1, 0, -1, -1);
        // Abort coincident with done on tile (k=1, n=0).
        run_job(2, 2, 0, 8, 0, 4, 16, 8, 1'b0, 1'b0, 2, 1, -1);
        // Reset while waiting on the core.
        run_job(2, 2, 0, 8, 0, 4, 16, 8, 1'b0, 1'b0, 3, -1, 2);

        for (int r = 0; r < 10; r++) begin
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 Parameters (name, default, meaning): W_SIZE 256 weight-buffer depth; I_SIZE 256 input-buffer depth; O_SIZE 256 output-buffer depth; TILE_W 8 tile-count width.
REQ-002 Ports (name  direction  width  meaning):
  clk_i  in  1  sole clock, rising edge
  rst_sync_i  in  1  synchronous active-high reset
  cmd_valid_i / cmd_ready_o  in/out  1/1  job command handshake
  cfg_k_tiles_i, cfg_n_tiles_i  in  TILE_W  reduction / output tile counts
  cfg_w_base_i, cfg_w_stride_i  in  $clog2(W_SIZE)  weight offset base / per-tile step
  cfg_i_base_i, cfg_i_stride_i  in  $clog2(I_SIZE)  input offset base / per-k step
  cfg_o_base_i, cfg_o_stride_i  in  $clog2(O_SIZE)  output offset base / per-n step
  abort_i  in  1  cancel current job
  mm_start_o  out  1  start pulse to matrix-mult core
  mm_done_i  in  1  tile-complete pulse from core
  mm_w_offset_o, mm_i_offset_o, mm_psum_offset_o, mm_o_offset_o  out  per buffer depth  core offsets
  mm_accum_en_o  out  1  accumulate partial sums
  tile_k_o, tile_n_o  out  TILE_W  current tile indices
  busy_o, done_o  out  1  job active / job-complete pulse
  perf_cycles_o  out  32  busy-cycle count
REQ-003 One clock; reset synchronous and active-high (clk_i, rst_sync_i).

Function
REQ-004 FSM states IDLE, ISSUE, WAIT, NEXT.
REQ-005 cmd_ready_o = 1 only in IDLE; a command is accepted when cmd_valid_i && cmd_ready_o; all cfg_* are latched on acceptance.
REQ-006 A tile count of 0 is latched as 1.
REQ-007 Accept at cycle T -> ISSUE at T+1 -> mm_start_o high exactly that one cycle -> WAIT.
REQ-008 WAIT: on mm_done_i go to NEXT; mm_done_i is ignored in every other state.
REQ-009 NEXT: if k==K-1 and n==N-1, pulse done_o for one cycle and go to IDLE; otherwise advance and go to ISSUE.
REQ-010 Tile order: k inner, n outer; on k==K-1, k<=0 and n<=n+1; otherwise k<=k+1.
REQ-011 mm_w_offset_o starts at w_base and adds w_stride on every advance.
REQ-012 mm_i_offset_o = i_base + k*i_stride, kept as a running sum that is reloaded to i_base when k wraps.
REQ-013 mm_o_offset_o = o_base + n*o_stride, kept as a running sum; mm_psum_offset_o equals mm_o_offset_o.
REQ-014 Offset arithmetic is modulo its buffer depth: unsigned, natural wrap, no saturation.
REQ-015 mm_accum_en_o = (k != 0).
REQ-016 All mm_* offsets and accum_en are stable from ISSUE through WAIT; they change only in NEXT.
REQ-017 Last mm_done_i at cycle D -> done_o at D+1.
REQ-018 Non-last mm_done_i at cycle D -> next mm_start_o at D+2.
REQ-019 busy_o = 1 in ISSUE, WAIT and NEXT.
REQ-020 abort_i in any non-IDLE state -> IDLE next cycle; no done_o; abort overrides a simultaneous mm_done_i.
REQ-021 abort_i in IDLE is ignored.
REQ-022 tile_k_o and tile_n_o reflect the current k and n counters.

Reset
REQ-023 rst_sync_i forces IDLE at the next edge, including mid-job.
REQ-024 After reset all outputs are 0 except cmd_ready_o, which is 1.
REQ-025 Reset overrides cmd_valid_i, abort_i and mm_done_i.

Configuration
REQ-026 Macro TILE_SEQ_PERF_EN, defined: perf_cycles_o clears on command acceptance, increments each busy_o cycle, saturates at 0xFFFFFFFF, and holds its value in IDLE.
REQ-027 Macro TILE_SEQ_PERF_EN, undefined: the counter is not built and perf_cycles_o is tied to 0.

Verification
REQ-028 K=2, N=2, w_base=0, w_stride=8, i_base=0, i_stride=4, o_base=16, o_stride=8, done 3 cycles after each start:
  - 4 starts with (w,i,o,accum) = (0,0,16,0), (8,4,16,1), (16,0,24,0), (24,4,24,1)
  - done_o 1 cycle after the 4th done
REQ-029 K=0, N=0 -> exactly one start with accum_en 0, then done_o.
REQ-030 W_SIZE=256, w_base=250, w_stride=8, K=2, N=1 -> w offsets 250, then 2 (wrap).
REQ-031 Handshake and spurious-done checks:
  - cmd_valid_i held high during a job -> no second accept until IDLE
  - mm_done_i pulsed in ISSUE -> ignored
REQ-032 abort_i asserted in the same cycle as mm_done_i during tile (1,0) -> IDLE next cycle, no done_o, cmd_ready_o = 1.
REQ-033 rst_sync_i in WAIT -> all outputs at reset values next cycle; with TILE_SEQ_PERF_EN, perf_cycles_o = 0.
